// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcode/function encodings, iterative-unit FSM states, sign extension.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dlx_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [4:0] FN_ADD  = 5'd0;
    localparam logic [4:0] FN_SUB  = 5'd1;
    localparam logic [4:0] FN_AND  = 5'd2;
    localparam logic [4:0] FN_OR   = 5'd3;
    localparam logic [4:0] FN_XOR  = 5'd4;
    localparam logic [4:0] FN_SLL  = 5'd5;
    localparam logic [4:0] FN_SRL  = 5'd6;
    localparam logic [4:0] FN_SRA  = 5'd7;
    localparam logic [4:0] FN_SLT  = 5'd8;
    localparam logic [4:0] FN_MULU = 5'd12;
    localparam logic [4:0] FN_DIVU = 5'd13;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_e;

    // Sign-extends the low 'width' bits of val to 32 bits.
    function automatic logic [31:0] sext(input logic [31:0] val, input int unsigned width);
        logic [31:0] shifted;
        shifted = val << (32 - width);
        return $unsigned($signed(shifted) >>> (32 - width));
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
// Latency: n/a (wiring only).
// Backpressure: stall_out travels from execute back toward decode.
interface execute_stage_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int PC_WIDTH        = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FUNCTION_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int IMMEDIATE_WIDTH = 16,
    parameter int PC_OFFSET_WIDTH = 26
);
    logic [DATA_WIDTH-1:0]      data_alu_a_in;
    logic [DATA_WIDTH-1:0]      data_alu_b_in;
    logic [PC_WIDTH-1:0]        new_pc_in;
    logic [OPCODE_WIDTH-1:0]    opcode_in;
    logic [FUNCTION_WIDTH-1:0]  inst_function_in;
    logic [REG_ADDR_WIDTH-1:0]  w_reg_addr_in;
    logic                       w_reg_wr_en_in;
    logic [IMMEDIATE_WIDTH-1:0] immediate_in;
    logic [PC_OFFSET_WIDTH-1:0] pc_offset_in;
    logic                       mem_data_wr_en_in;
    logic                       write_back_mux_sel_in;
    logic                       branch_inst_in;
    logic                       jump_inst_in;

    logic                       stall_out;
    logic [DATA_WIDTH-1:0]      alu_result_out;
    logic [DATA_WIDTH-1:0]      store_data_out;
    logic [REG_ADDR_WIDTH-1:0]  w_reg_addr_out;
    logic                       w_reg_wr_en_out;
    logic                       mem_data_wr_en_out;
    logic                       write_back_mux_sel_out;
    logic                       pc_redirect_out;
    logic [PC_WIDTH-1:0]        pc_target_out;

    modport master (
        output data_alu_a_in, data_alu_b_in, new_pc_in, opcode_in, inst_function_in,
               w_reg_addr_in, w_reg_wr_en_in, immediate_in, pc_offset_in,
               mem_data_wr_en_in, write_back_mux_sel_in, branch_inst_in, jump_inst_in,
        input  stall_out, alu_result_out, store_data_out, w_reg_addr_out, w_reg_wr_en_out,
               mem_data_wr_en_out, write_back_mux_sel_out, pc_redirect_out, pc_target_out
    );

    modport slave (
        input  data_alu_a_in, data_alu_b_in, new_pc_in, opcode_in, inst_function_in,
               w_reg_addr_in, w_reg_wr_en_in, immediate_in, pc_offset_in,
               mem_data_wr_en_in, write_back_mux_sel_in, branch_inst_in, jump_inst_in,
        output stall_out, alu_result_out, store_data_out, w_reg_addr_out, w_reg_wr_en_out,
               mem_data_wr_en_out, write_back_mux_sel_out, pc_redirect_out, pc_target_out
    );
endinterface

// File: rtl/execute_stage_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// Latency: start cycle + DATA_WIDTH BUSY cycles, result valid during the single DONE cycle.
// Backpressure: none; caller holds operands and keeps start low while busy/done.
module muldiv_iter
    import dlx_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    md_state_e             state_q, state_d;
    logic                  op_q, op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // mul: x = shifted multiplicand, y = remaining multiplier, acc = product
    // div: x = dividend shifting out / quotient shifting in, y = divisor, acc = remainder
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH:0]   trial;
    logic                  q_bit;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        trial   = {acc_q, x_q[DATA_WIDTH-1]};
        q_bit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    x_d     = a;
                    y_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!op_q) begin
                    if (y_q[0]) begin
                        acc_d = acc_q + x_q;
                    end
                    x_d = x_q << 1;
                    y_d = y_q >> 1;
                end else begin
                    // A zero divisor lets every trial subtract succeed, giving all-ones.
                    if (trial >= {1'b0, y_q}) begin
                        acc_d = DATA_WIDTH'(trial - {1'b0, y_q});
                        q_bit = 1'b1;
                    end else begin
                        acc_d = trial[DATA_WIDTH-1:0];
                    end
                    x_d = {x_q[DATA_WIDTH-2:0], q_bit};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign done   = (state_q == DONE);
    assign result = op_q ? x_q : acc_q;

endmodule

// File: rtl/execute_stage.sv
// DLX execute stage: ALU, branch/jump resolution, iterative MULU/DIVU, EX/MEM register.
// Latency: 1 cycle for single-cycle ops; MULU/DIVU DATA_WIDTH+2 cycles.
// Backpressure: combinational stall_out holds ID/EX while MULU/DIVU runs; bubbles issued meanwhile.
module execute_stage
    import dlx_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PC_WIDTH        = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FUNCTION_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int IMMEDIATE_WIDTH = 16,
    parameter int PC_OFFSET_WIDTH = 26
) (
    input  logic           clk,
    input  logic           rst_n,
    execute_stage_if.slave bus
);
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [FUNCTION_WIDTH-1:0] fn;
    logic [DATA_WIDTH-1:0]     a, b, imm_ext, alu_res, md_result;
    logic [PC_WIDTH-1:0]       br_off, j_off, target;
    logic                      is_md, md_start, md_busy, md_done, stall, taken, redirect;

    logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
    logic [DATA_WIDTH-1:0]     store_data_q, store_data_d;
    logic [REG_ADDR_WIDTH-1:0] w_reg_addr_q, w_reg_addr_d;
    logic                      w_reg_wr_en_q, w_reg_wr_en_d;
    logic                      mem_data_wr_en_q, mem_data_wr_en_d;
    logic                      write_back_mux_sel_q, write_back_mux_sel_d;
    logic                      pc_redirect_q, pc_redirect_d;
    logic [PC_WIDTH-1:0]       pc_target_q, pc_target_d;

    assign opcode  = bus.opcode_in;
    assign fn      = bus.inst_function_in;
    assign a       = bus.data_alu_a_in;
    assign b       = bus.data_alu_b_in;
    assign imm_ext = DATA_WIDTH'(sext(32'(bus.immediate_in), IMMEDIATE_WIDTH));
    assign br_off  = PC_WIDTH'(sext(32'(bus.immediate_in), IMMEDIATE_WIDTH));
    assign j_off   = PC_WIDTH'(sext(32'(bus.pc_offset_in), PC_OFFSET_WIDTH));

    // busy/done both low means the iterative unit is idle and may launch.
    assign is_md    = (opcode == OP_R) && ((fn == FN_MULU) || (fn == FN_DIVU));
    assign md_start = is_md && !md_busy && !md_done;
    assign stall    = md_start || md_busy;

    muldiv_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (fn == FN_DIVU),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_R: begin
                case (fn)
                    FN_ADD:  alu_res = a + b;
                    FN_SUB:  alu_res = a - b;
                    FN_AND:  alu_res = a & b;
                    FN_OR:   alu_res = a | b;
                    FN_XOR:  alu_res = a ^ b;
                    FN_SLL:  alu_res = a << b[4:0];
                    FN_SRL:  alu_res = a >> b[4:0];
                    FN_SRA:  alu_res = $signed(a) >>> b[4:0];
                    FN_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a + imm_ext;
            OP_J:                  alu_res = DATA_WIDTH'(bus.new_pc_in);
            default:               alu_res = '0;
        endcase
        if (md_done) begin
            alu_res = md_result;
        end
    end

    assign taken    = bus.branch_inst_in &&
                      (((opcode == OP_BEQZ) && (a == '0)) || ((opcode == OP_BNEZ) && (a != '0)));
    assign redirect = taken || bus.jump_inst_in;
    assign target   = bus.new_pc_in + (bus.jump_inst_in ? j_off : br_off);

    always_comb begin
        alu_result_d         = alu_res;
        store_data_d         = b;
        w_reg_addr_d         = bus.w_reg_addr_in;
        write_back_mux_sel_d = bus.write_back_mux_sel_in;
        pc_target_d          = target;
        w_reg_wr_en_d        = bus.w_reg_wr_en_in && !stall;
        mem_data_wr_en_d     = bus.mem_data_wr_en_in && !stall;
        pc_redirect_d        = redirect && !stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q         <= '0;
            store_data_q         <= '0;
            w_reg_addr_q         <= '0;
            w_reg_wr_en_q        <= 1'b0;
            mem_data_wr_en_q     <= 1'b0;
            write_back_mux_sel_q <= 1'b0;
            pc_redirect_q        <= 1'b0;
            pc_target_q          <= '0;
        end else begin
            alu_result_q         <= alu_result_d;
            store_data_q         <= store_data_d;
            w_reg_addr_q         <= w_reg_addr_d;
            w_reg_wr_en_q        <= w_reg_wr_en_d;
            mem_data_wr_en_q     <= mem_data_wr_en_d;
            write_back_mux_sel_q <= write_back_mux_sel_d;
            pc_redirect_q        <= pc_redirect_d;
            pc_target_q          <= pc_target_d;
        end
    end

    assign bus.stall_out              = stall;
    assign bus.alu_result_out         = alu_result_q;
    assign bus.store_data_out         = store_data_q;
    assign bus.w_reg_addr_out         = w_reg_addr_q;
    assign bus.w_reg_wr_en_out        = w_reg_wr_en_q;
    assign bus.mem_data_wr_en_out     = mem_data_wr_en_q;
    assign bus.write_back_mux_sel_out = write_back_mux_sel_q;
    assign bus.pc_redirect_out        = pc_redirect_q;
    assign bus.pc_target_out          = pc_target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expectations, a monitor pops and compares.
module tb_execute_stage;
    import dlx_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_stage_if ex_if();

    execute_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ex_if)
    );

    typedef struct {
        logic [31:0] alu;
        logic        chk_alu;
        logic [31:0] store;
        logic [4:0]  waddr;
        logic        wen;
        logic        memwr;
        logic        wbsel;
        logic        redir;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic in_valid = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [15:0] imm,
                         input logic [25:0] off, input logic [4:0] wa, input logic wen,
                         input logic memwr, input logic wbsel, input logic br, input logic jmp);
        ex_if.opcode_in             = op;
        ex_if.inst_function_in      = fn;
        ex_if.data_alu_a_in         = a;
        ex_if.data_alu_b_in         = b;
        ex_if.new_pc_in             = pc;
        ex_if.immediate_in          = imm;
        ex_if.pc_offset_in          = off;
        ex_if.w_reg_addr_in         = wa;
        ex_if.w_reg_wr_en_in        = wen;
        ex_if.mem_data_wr_en_in     = memwr;
        ex_if.write_back_mux_sel_in = wbsel;
        ex_if.branch_inst_in        = br;
        ex_if.jump_inst_in          = jmp;
    endtask

    task automatic nop();
        drive(OP_R, FN_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        nop();
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one instruction, holds it through any stall, returns #1 after its retiring edge.
    task automatic issue(input logic [5:0] op, input logic [4:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [15:0] imm,
                         input logic [25:0] off, input logic [4:0] wa, input logic wen,
                         input logic memwr, input logic wbsel, input logic br, input logic jmp,
                         input logic [31:0] e_alu, input logic e_chk, input logic e_red,
                         input logic [31:0] e_tgt, input int e_stall, input string name);
        exp_t e;
        int   n;
        logic s;
        drive(op, fn, a, b, pc, imm, off, wa, wen, memwr, wbsel, br, jmp);
        in_valid  = 1'b1;
        e.alu     = e_alu;
        e.chk_alu = e_chk;
        e.store   = b;
        e.waddr   = wa;
        e.wen     = wen;
        e.memwr   = memwr;
        e.wbsel   = wbsel;
        e.redir   = e_red;
        e.target  = e_tgt;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            s = ex_if.stall_out;
            if (s) n++;
        end while (s && n <= 100);
        @(posedge clk);
        #1;
        chk({name, "_stall_cycles"}, 32'(n), 32'(e_stall));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_alu"},    ex_if.alu_result_out, 0);
        chk({name, "_store"},  ex_if.store_data_out, 0);
        chk({name, "_waddr"},  32'(ex_if.w_reg_addr_out), 0);
        chk({name, "_wen"},    32'(ex_if.w_reg_wr_en_out), 0);
        chk({name, "_memwr"},  32'(ex_if.mem_data_wr_en_out), 0);
        chk({name, "_wbsel"},  32'(ex_if.write_back_mux_sel_out), 0);
        chk({name, "_redir"},  32'(ex_if.pc_redirect_out), 0);
        chk({name, "_target"}, ex_if.pc_target_out, 0);
        chk({name, "_stall"},  32'(ex_if.stall_out), 0);
    endtask

    // Monitor: each negedge looks at what the previous cycle registered.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("bubble_wen",   32'(ex_if.w_reg_wr_en_out), 0);
                    chk("bubble_memwr", 32'(ex_if.mem_data_wr_en_out), 0);
                    chk("bubble_redir", 32'(ex_if.pc_redirect_out), 0);
                end else if (prev_valid) begin
                    if (sb.size() == 0) begin
                        chk("sb_occupancy", 32'(sb.size()), 1);
                    end else begin
                        e = sb.pop_front();
                        if (e.chk_alu) chk("alu_result", ex_if.alu_result_out, e.alu);
                        chk("store_data", ex_if.store_data_out, e.store);
                        chk("w_reg_addr", 32'(ex_if.w_reg_addr_out), 32'(e.waddr));
                        chk("w_reg_wr_en", 32'(ex_if.w_reg_wr_en_out), 32'(e.wen));
                        chk("mem_wr_en", 32'(ex_if.mem_data_wr_en_out), 32'(e.memwr));
                        chk("wb_sel", 32'(ex_if.write_back_mux_sel_out), 32'(e.wbsel));
                        chk("pc_redirect", 32'(ex_if.pc_redirect_out), 32'(e.redir));
                        if (e.redir) chk("pc_target", ex_if.pc_target_out, e.target);
                    end
                end
                prev_valid = in_valid;
                prev_stall = ex_if.stall_out;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nop();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_idle");
        rst_n = 1'b1;
        idle(2);

        //    op       fn       a             b             pc            imm       off            wa  wen mw wb br j   e_alu         chk red tgt           stl name
        issue(OP_R,    FN_ADD,  32'hFFFF_FFFF, 32'h1,       0,            0,        0,             3,  1, 0, 0, 0, 0, 32'h0,         1,  0,  0,            0,  "add_wrap");
        issue(OP_R,    FN_SRA,  32'h8000_0000, 32'h4,       0,            0,        0,             4,  1, 0, 0, 0, 0, 32'hF800_0000, 1,  0,  0,            0,  "sra");
        issue(OP_R,    FN_SUB,  32'h5,         32'h7,       0,            0,        0,             5,  1, 0, 0, 0, 0, 32'hFFFF_FFFE, 1,  0,  0,            0,  "sub");
        issue(OP_R,    FN_SLT,  32'hFFFF_FFFF, 32'h1,       0,            0,        0,             6,  1, 0, 0, 0, 0, 32'h1,         1,  0,  0,            0,  "slt_neg");
        issue(OP_R,    FN_SLT,  32'h1,         32'hFFFF_FFFF, 0,          0,        0,             6,  1, 0, 0, 0, 0, 32'h0,         1,  0,  0,            0,  "slt_pos");
        issue(OP_R,    FN_SLL,  32'h1,         32'd31,      0,            0,        0,             8,  1, 0, 0, 0, 0, 32'h8000_0000, 1,  0,  0,            0,  "sll");
        issue(OP_R,    FN_SRL,  32'h8000_0000, 32'h4,       0,            0,        0,             9,  1, 0, 0, 0, 0, 32'h0800_0000, 1,  0,  0,            0,  "srl");
        issue(OP_R,    FN_AND,  32'hF0F0,      32'hFF00,    0,            0,        0,             10, 1, 0, 0, 0, 0, 32'hF000,      1,  0,  0,            0,  "and");
        issue(OP_R,    FN_OR,   32'hF0F0,      32'hFF00,    0,            0,        0,             11, 1, 0, 0, 0, 0, 32'hFFF0,      1,  0,  0,            0,  "or");
        issue(OP_R,    FN_XOR,  32'hF0F0,      32'hFF00,    0,            0,        0,             12, 1, 0, 0, 0, 0, 32'h0FF0,      1,  0,  0,            0,  "xor");
        issue(OP_R,    5'd9,    32'h1234,      32'h5678,    0,            0,        0,             13, 1, 0, 0, 0, 0, 32'h0,         1,  0,  0,            0,  "bad_fn");
        issue(OP_ADDI, FN_ADD,  32'd10,        32'h0,       0,            16'hFFFE, 0,             14, 1, 0, 0, 0, 0, 32'd8,         1,  0,  0,            0,  "addi_neg");
        issue(OP_LW,   FN_ADD,  32'h200,       32'h0,       0,            16'h0004, 0,             15, 1, 0, 1, 0, 0, 32'h204,       1,  0,  0,            0,  "lw");
        issue(OP_SW,   FN_ADD,  32'h100,       32'hCAFE,    0,            16'hFFFC, 0,             0,  0, 1, 0, 0, 0, 32'hFC,        1,  0,  0,            0,  "sw");
        issue(OP_BNEZ, FN_ADD,  32'h5,         32'h0,       32'h40,       16'hFFF0, 0,             0,  0, 0, 0, 1, 0, 32'h0,         0,  1,  32'h30,       0,  "bnez_taken");
        issue(OP_BEQZ, FN_ADD,  32'h5,         32'h0,       32'h40,       16'hFFF0, 0,             0,  0, 0, 0, 1, 0, 32'h0,         0,  0,  32'h0,        0,  "beqz_not");
        issue(OP_BEQZ, FN_ADD,  32'h0,         32'h0,       32'h80,       16'h0008, 0,             0,  0, 0, 0, 1, 0, 32'h0,         0,  1,  32'h88,       0,  "beqz_taken");
        issue(OP_J,    FN_ADD,  32'h0,         32'h0,       32'h100,      0,        26'h3FF_FFF0,  31, 1, 0, 0, 0, 1, 32'h100,       1,  1,  32'hF0,       0,  "jump_link");
        issue(OP_R,    FN_MULU, 32'd7,         32'd6,       0,            0,        0,             7,  1, 0, 0, 0, 0, 32'd42,        1,  0,  0,            33, "mulu");
        issue(OP_R,    FN_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,          0,        0,             16, 1, 0, 0, 0, 0, 32'h1,         1,  0,  0,            33, "mulu_b2b");
        issue(OP_R,    FN_DIVU, 32'd100,       32'd0,       0,            0,        0,             17, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1,  0,  0,            33, "divu_zero");
        issue(OP_R,    FN_DIVU, 32'd100,       32'd7,       0,            0,        0,             18, 1, 0, 0, 0, 0, 32'd14,        1,  0,  0,            33, "divu");
        issue(OP_R,    FN_DIVU, 32'hFFFF_FFFF, 32'h10,      0,            0,        0,             19, 1, 0, 0, 0, 0, 32'h0FFF_FFFF, 1,  0,  0,            33, "divu_big");
        issue(OP_R,    FN_ADD,  32'd2,         32'd3,       0,            0,        0,             20, 1, 0, 0, 0, 0, 32'd5,         1,  0,  0,            0,  "add_after_md");
        idle(2);

        // Abort a DIVU part-way through with reset.
        drive(OP_R, FN_DIVU, 32'd100, 32'd7, 0, 0, 0, 21, 1, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        nop();
        #1;
        check_zero("rst_busy");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(40);
        chk("post_rst_wen", 32'(ex_if.w_reg_wr_en_out), 0);
        chk("post_rst_alu", ex_if.alu_result_out, 0);
        chk("post_rst_stall", 32'(ex_if.stall_out), 0);
        issue(OP_R,    FN_ADD,  32'd9,         32'd1,       0,            0,        0,             22, 1, 0, 0, 0, 0, 32'd10,        1,  0,  0,            0,  "add_after_rst");
        idle(3);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage DLX pipeline. It consumes the registered ID/EX bundle produced by decode and performs ALU operations, branch and jump resolution, and iterative unsigned multiply/divide. It registers the results into the EX/MEM bundle. During multi-cycle operations it drives `stall_out` so that the ID/EX register and the earlier stages hold their contents.

## Interface
- `DATA_WIDTH`, 32: operand and result width.
- `PC_WIDTH`, 32: program counter width.
- `OPCODE_WIDTH`, 6: opcode field width.
- `FUNCTION_WIDTH`, 5: R-type function field width.
- `REG_ADDR_WIDTH`, 5: register address width.
- `IMMEDIATE_WIDTH`, 16: I-type immediate width.
- `PC_OFFSET_WIDTH`, 26: J-type offset width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_alu_a_in` in DATA_WIDTH: rs1 value.
- `data_alu_b_in` in DATA_WIDTH: rs2 value, also the store data.
- `new_pc_in` in PC_WIDTH: PC+4 of the instruction.
- `opcode_in` in OPCODE_WIDTH: opcode.
- `inst_function_in` in FUNCTION_WIDTH: R-type function.
- `w_reg_addr_in` in REG_ADDR_WIDTH: destination register.
- `w_reg_wr_en_in` in 1: register write enable.
- `immediate_in` in IMMEDIATE_WIDTH: immediate, sign-extended internally.
- `pc_offset_in` in PC_OFFSET_WIDTH: jump offset, sign-extended internally.
- `mem_data_wr_en_in` in 1: store enable.
- `write_back_mux_sel_in` in 1: 1 selects memory data at writeback.
- `branch_inst_in` in 1: conditional branch.
- `jump_inst_in` in 1: unconditional jump.
- `stall_out` out 1: hold request to decode and fetch; combinational.
- `alu_result_out` out DATA_WIDTH: result or memory address.
- `store_data_out` out DATA_WIDTH: registered `data_alu_b_in`.
- `w_reg_addr_out` out REG_ADDR_WIDTH: registered destination register.
- `w_reg_wr_en_out` out 1: registered register write enable.
- `mem_data_wr_en_out` out 1: registered store enable.
- `write_back_mux_sel_out` out 1: registered writeback select.
- `pc_redirect_out` out 1: branch taken or jump.
- `pc_target_out` out PC_WIDTH: redirect target.

## Operation
- Reset values: every registered output is 0 and the FSM is in IDLE.
- Opcodes:
  - R=6'h00
  - ADDI=6'h08
  - LW=6'h23
  - SW=6'h2B
  - BEQZ=6'h04
  - BNEZ=6'h05
  - J=6'h02
- Functions:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4
  - SLL=5, SRL=6, SRA=7 (shift amount is b[4:0])
  - SLT=8 (signed compare, result 0 or 1)
  - MULU=12, DIVU=13
  - Any other function produces result 0.
- ADDI, LW and SW compute a + sext(imm). All adds wrap modulo 2^DATA_WIDTH.
- BEQZ and BNEZ test a==0 and a!=0 respectively. Target is new_pc + sext(imm).
- J always redirects. Target is new_pc + sext(pc_offset). J writes new_pc into alu_result, so a link is possible when wr_en is set.
- MULU returns the low DATA_WIDTH bits of a*b. The multiplier is shift-add, one bit per cycle.
- DIVU returns the quotient of a restoring divide, one bit per cycle. Divide by zero returns all ones.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with a MULU/DIVU input: latch operands, clear the counter, go to BUSY.
  - BUSY: one iteration per cycle. When the counter reaches DATA_WIDTH-1, go to DONE.
  - DONE: register the result with the held control fields, then return to IDLE.
- `stall_out` = (MULU/DIVU at the input in IDLE) or (state==BUSY).
- Every cycle with `stall_out`=1, EX/MEM registers a bubble: wr_en=0, mem_wr=0 and redirect=0. The data fields are don't-care.
- While `stall_out`=1 the upstream must hold all inputs stable. The block does not re-check input changes.
- Reset asserted mid-operation aborts immediately. State and all outputs clear, and no result is produced.

## Timing
- Single-cycle operations: inputs present in cycle N appear on the EX/MEM outputs after edge N+1. Throughput is one per cycle. `stall_out`=0.
- MULU/DIVU occupies EX for DATA_WIDTH+2 cycles: one launch cycle, DATA_WIDTH iterations, and DONE.
  - `stall_out` is high for the first DATA_WIDTH+1 cycles.
  - The result is registered at the end of DONE.
  - The next instruction enters the cycle after DONE.
- Back-to-back MULU instructions: the second launches in the cycle after DONE. No idle gap beyond that.
- Redirect is registered. Fetch and decode flushing is owned outside this block.

## Structure
- Shared package `dlx_pkg`: opcode and function constants, FSM state enum, and the sign-extend helper function.
- One sub-module, `muldiv_iter`, holds the iterative multiplier/divider. Its interface is start, op, a, b, busy, done and result.
- The ALU, branch logic and EX/MEM register stay in `execute_stage`.

## Test plan
- Reset during idle and mid-DIVU, then release: all outputs 0, `stall_out`=0, no stale result.
- ADD with a=32'hFFFF_FFFF, b=1 → alu_result 0 one cycle later. SRA with a=32'h8000_0000, b=4 → 32'hF800_0000.
- SW with a=32'h100, imm=16'hFFFC, b=32'hCAFE → alu_result 32'hFC, store_data 32'hCAFE, mem_wr 1.
- BNEZ with a=5, new_pc=32'h40, imm=16'hFFF0 → redirect 1, target 32'h30. BEQZ with a=5 → redirect 0.
- MULU with a=7, b=6 → `stall_out` high for 33 cycles, bubbles on EX/MEM meanwhile, then result 42 with wr_en 1.
- DIVU with a=100, b=0 → result 32'hFFFF_FFFF. DIVU with a=100, b=7 → result 14.
